demod_channel_scheduler: RTL
============================

Name: demod_channel_scheduler

Overview:
- Shares one phase-difference FM demodulation datapath among NUM_CH AXI-Stream channels of CORDIC output, each carrying the angle in [31:16] and the magnitude in [15:0].
- A round-robin arbiter grants one channel per accepted beat and keeps a per-channel previous-angle register.
- It emits one tagged, demodulated sample per accepted input beat.
- It sits between the per-channel CORDIC blocks and the downstream audio filter/decimator.

Parameters:
- NUM_CH, 4: number of input channels; 2..8.
- CH_W, 2: channel index width, equal to clog2(NUM_CH) with a minimum of 1.
- LOCK_PACKET, 0: 1 holds the grant on one channel until its tlast beat is accepted; 0 re-arbitrates on every beat.
- C_S00_AXIS_TDATA_WIDTH, 32: width of each input channel's tdata.
- C_M00_AXIS_TDATA_WIDTH, 32: width of the output tdata.

Ports:
- s00_axis_aclk  in  1  clock
- s00_axis_aresetn  in  1  asynchronous active-low reset
- s00_axis_tvalid  in  NUM_CH  per-channel valid
- s00_axis_tdata  in  NUM_CH*32  channel k occupies bits [32k+31:32k]; angle in [32k+31:32k+16]
- s00_axis_tlast  in  NUM_CH  per-channel last
- s00_axis_tready  out  NUM_CH  per-channel ready, one-hot or zero
- clear_history  in  NUM_CH  synchronous pulse that un-primes the channel's angle history
- m00_axis_tready  in  1  downstream ready
- m00_axis_tvalid  out  1  output valid
- m00_axis_tlast  out  1  tlast of the source beat
- m00_axis_tdata  out  32  [15:0] demod sample (signed), [16+CH_W-1:16] channel index, all other bits 0
- m00_axis_tstrb  out  4  constant 4'hF whenever m00_axis_tvalid is high
- busy_ch  out  CH_W  channel currently locked; meaningful only while locked
- locked  out  1  high while a LOCK_PACKET grant is held

Behaviour:
Clock and reset
- One clock. Reset is asynchronous and active-low on s00_axis_aresetn.
- Values held in reset: m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, m00_axis_tstrb=0, locked=0, busy_ch=0.
- Also cleared in reset: rr_ptr=NUM_CH-1, all prev_angle=0, all primed=0.

Accept condition
- out_free = m00_axis_tready | ~m00_axis_tvalid.
- Grant is combinational in the same cycle.
- When unlocked, grant goes to the first channel with tvalid high, searching from rr_ptr+1 upward modulo NUM_CH.
- When locked, grant goes only to busy_ch.
- s00_axis_tready[g] = out_free & granted. Every other bit is 0. No grant means all bits are 0.
- Accept means tvalid[g] & tready[g].

Arbiter state machine (ARB and LOCK)
- ARB: on accept, rr_ptr<=g.
  - If LOCK_PACKET=1 and tlast[g]=0: move to LOCK with busy_ch<=g and locked<=1.
- LOCK: only busy_ch is served.
  - On an accepted beat with tlast=1: rr_ptr<=busy_ch, locked<=0, return to ARB.
  - A locked channel that drops tvalid keeps the lock; no other channel is served (starvation is by design).
- LOCK_PACKET=0: the block never leaves ARB.

Datapath, on accept of channel g with angle a
- d = a - prev_angle[g], taken modulo 2^16 and interpreted as signed 16-bit. Wrap across ±pi is handled by the modular subtraction.
- sample = d >>> 1, arithmetic shift, so the result range is -16384..16383.
- If primed[g]=0: sample=0 and primed[g]<=1.
- Always: prev_angle[g]<=a.
- Output register loads, with latency 1 cycle: tdata = {zeros, g, sample}, tlast=tlast[g], tstrb=4'hF, tvalid=1.
- Without a new accept, an output beat taken (tvalid & tready) drops tvalid to 0.
- Full throughput: one beat per cycle while m00_axis_tready=1.

Boundary conditions
- Simultaneous clear_history[g] and accept on g: the accept's sample is computed as un-primed (value 0), and the channel ends primed with prev_angle=a.
- clear_history on another channel: primed<=0 for that channel only.
- Output stalled (tvalid=1, tready=0): all input tready bits are 0, and the output holds stable.
- Reset mid-packet: the lock is dropped, and history and output are cleared immediately.
- Inputs ignored by the block: each channel's magnitude bits [15:0] and the upstream tstrb.

Test Plan:
1. NUM_CH=4, LOCK_PACKET=0, all channels valid continuously, tready=1 → grants in order 0,1,2,3,0,…; one output per cycle; tdata[17:16] follows the same sequence.
2. Channel 1 angles 0x1000, 0x3000, 0x2000 → samples 0x0000 (un-primed), 0x1000, 0xF800 (-2048).
3. Wrap: channel 0 angles 0x7F00 then 0x8100 → d=0x0200, sample 0x0100. Then 0xFF00 followed by 0x0100 → sample 0x0100.
4. Backpressure: hold m00_axis_tready=0 for 5 cycles with tvalid=1 → s00_axis_tready=0 and output data stable throughout; after release, no beat is lost or duplicated.
5. LOCK_PACKET=1: channel 2 sends a 3-beat packet while channel 0 is also valid → three consecutive channel 2 outputs with tlast on the 3rd; locked=1 for beats 1-2; channel 0 is served next.
6. clear_history[3] pulsed on the same cycle as a channel 3 accept → output sample 0; the next channel 3 beat gives (a2-a1)>>>1. Asserting reset mid-LOCK → locked=0 and m00_axis_tvalid=0 immediately.

Source files
------------

// File: rtl/demod_channel_scheduler.sv
// rtl/demod_channel_scheduler.sv - round-robin shared FM phase-difference demodulator for NUM_CH CORDIC streams
module demod_channel_scheduler #(
  parameter int NUM_CH                 = 4,
  parameter int CH_W                   = 2,
  parameter int LOCK_PACKET            = 0,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                     s00_axis_aclk,
  input  logic                                     s00_axis_aresetn,
  input  logic [NUM_CH-1:0]                        s00_axis_tvalid,
  input  logic [NUM_CH*C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [NUM_CH-1:0]                        s00_axis_tlast,
  output logic [NUM_CH-1:0]                        s00_axis_tready,
  input  logic [NUM_CH-1:0]                        clear_history,
  input  logic                                     m00_axis_tready,
  output logic                                     m00_axis_tvalid,
  output logic                                     m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]        m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]      m00_axis_tstrb,
  output logic [CH_W-1:0]                          busy_ch,
  output logic                                     locked
);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t                              state_q, state_d;
  logic [CH_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]                     busy_ch_q, busy_ch_d;
  logic [15:0]                         prev_angle_q [NUM_CH];
  logic [15:0]                         prev_angle_d [NUM_CH];
  logic [NUM_CH-1:0]                   primed_q, primed_d;
  logic                                out_vld_q, out_vld_d;
  logic                                out_last_q, out_last_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] out_strb_q, out_strb_d;

  logic            out_free, grant_vld, accept, grant_last;
  logic [CH_W-1:0] grant_ch;
  logic [15:0]     angle, diff, sample;
  logic            unused_bits;

  assign out_free = m00_axis_tready | ~out_vld_q;

  // Farthest candidate first so the nearest valid channel after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    if (state_q == ST_LOCK) begin
      grant_vld = s00_axis_tvalid[busy_ch_q];
      grant_ch  = busy_ch_q;
    end else begin
      for (int i = NUM_CH; i >= 1; i--) begin
        if (s00_axis_tvalid[(int'(rr_ptr_q) + i) % NUM_CH]) begin
          grant_vld = 1'b1;
          grant_ch  = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
        end
      end
    end
  end

  assign accept     = grant_vld & out_free;
  assign grant_last = s00_axis_tlast[grant_ch];

  always_comb begin
    s00_axis_tready = '0;
    if (accept) s00_axis_tready[grant_ch] = 1'b1;
  end

  assign angle = s00_axis_tdata[int'(grant_ch)*C_S00_AXIS_TDATA_WIDTH + C_S00_AXIS_TDATA_WIDTH - 16 +: 16];
  // Modular 16-bit subtraction handles the +/-pi wrap for free.
  assign diff  = angle - prev_angle_q[grant_ch];

  always_comb begin
    sample = '0;
    if (primed_q[grant_ch] && !clear_history[grant_ch]) sample = {diff[15], diff[15:1]};
  end

  always_comb begin
    unused_bits = diff[0];
    for (int k = 0; k < NUM_CH; k++) begin
      unused_bits = unused_bits ^ (^s00_axis_tdata[k*C_S00_AXIS_TDATA_WIDTH +: C_S00_AXIS_TDATA_WIDTH-16]);
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    busy_ch_d = busy_ch_q;
    if (accept) begin
      if (state_q == ST_ARB) begin
        rr_ptr_d = grant_ch;
        if ((LOCK_PACKET != 0) && !grant_last) begin
          state_d   = ST_LOCK;
          busy_ch_d = grant_ch;
        end
      end else if (grant_last) begin
        rr_ptr_d = busy_ch_q;
        state_d  = ST_ARB;
      end
    end
  end

  always_comb begin
    prev_angle_d = prev_angle_q;
    primed_d     = primed_q & ~clear_history;
    out_vld_d    = out_vld_q & ~m00_axis_tready;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    out_strb_d   = out_strb_q;
    if (accept) begin
      prev_angle_d[grant_ch]   = angle;
      primed_d[grant_ch]       = 1'b1;
      out_vld_d                = 1'b1;
      out_last_d               = grant_last;
      out_strb_d               = '1;
      out_data_d               = '0;
      out_data_d[15:0]         = sample;
      out_data_d[16 +: CH_W]   = grant_ch;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= CH_W'(NUM_CH-1);
      busy_ch_q  <= '0;
      primed_q   <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      out_strb_q <= '0;
      for (int k = 0; k < NUM_CH; k++) prev_angle_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_ch_q    <= busy_ch_d;
      primed_q     <= primed_d;
      out_vld_q    <= out_vld_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      prev_angle_q <= prev_angle_d;
    end
  end

  assign m00_axis_tvalid = out_vld_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tdata  = out_data_q;
  assign m00_axis_tstrb  = out_strb_q;
  assign busy_ch         = busy_ch_q;
  assign locked          = (state_q == ST_LOCK);

endmodule
